instr_loader: RTL

Program loader for the bitty instruction memory. Accepts a byte stream over a valid/ready handshake, assembles 16-bit instructions high byte first, and writes them to sequential instruction-memory addresses from 0. It holds the bitty core and PC in reset while loading, checks an XOR checksum, and pulses completion. It is the write-side counterpart of the fetch path that reads instruction memory through the PC.

---
 rtl/instr_loader_if.sv | 22 ++
 rtl/instr_loader.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/instr_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
interface instr_loader_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;

    // master: byte source / memory sink; slave: the loader itself
    modport master (
        output byte_valid, byte_data,
        input  byte_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  byte_valid, byte_data,
        output byte_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/instr_loader.sv
// Program loader: assembles a COUNT/HI/LO.../CHK byte stream into 16-bit words,
// writes them to instruction memory from address 0 and checks an XOR checksum.
module instr_loader #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    instr_loader_if.slave  bus,
    output logic           hold_core,
    output logic           load_done,
    output logic           load_err
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_HI,
        S_LO,
        S_WRITE,
        S_CHECK,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  remaining_q, remaining_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic [7:0]        chk_q, chk_d;
    logic              err_q, err_d;
    logic              ready_q, ready_d;
    logic              we_q, we_d;
    logic              hold_q, hold_d;
    logic              done_q, done_d;
    logic              accept;

    assign accept = bus.byte_valid && ready_q;

    // Next-state, datapath updates, and output decode of the upcoming state
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        chk_d       = chk_q;
        err_d       = err_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    err_d   = 1'b0;
                    chk_d   = 8'h00;
                    addr_d  = '0;
                    state_d = S_COUNT;
                end
            end
            S_COUNT: begin
                if (accept) begin
                    // A zero count means a full 2^ADDR_W-word image
                    remaining_d = (bus.byte_data == 8'h00) ? {1'b1, {ADDR_W{1'b0}}}
                                                           : CNT_W'(bus.byte_data);
                    chk_d       = chk_q ^ bus.byte_data;
                    state_d     = S_HI;
                end
            end
            S_HI: begin
                if (accept) begin
                    wdata_d[15:8] = bus.byte_data;
                    chk_d         = chk_q ^ bus.byte_data;
                    state_d       = S_LO;
                end
            end
            S_LO: begin
                if (accept) begin
                    wdata_d[7:0] = bus.byte_data;
                    chk_d        = chk_q ^ bus.byte_data;
                    state_d      = S_WRITE;
                end
            end
            S_WRITE: begin
                addr_d      = addr_q + ADDR_W'(1);
                remaining_d = remaining_q - CNT_W'(1);
                state_d     = (remaining_q == CNT_W'(1)) ? S_CHECK : S_HI;
            end
            S_CHECK: begin
                if (accept) begin
                    err_d   = (bus.byte_data != chk_q);
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ready_d = (state_d == S_COUNT) || (state_d == S_HI) ||
                  (state_d == S_LO)    || (state_d == S_CHECK);
        we_d    = (state_d == S_WRITE);
        hold_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            chk_q       <= '0;
            err_q       <= 1'b0;
            ready_q     <= 1'b0;
            we_q        <= 1'b0;
            hold_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            chk_q       <= chk_d;
            err_q       <= err_d;
            ready_q     <= ready_d;
            we_q        <= we_d;
            hold_q      <= hold_d;
            done_q      <= done_d;
        end
    end

    assign bus.byte_ready = ready_q;
    assign bus.mem_we     = we_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = wdata_q;
    assign hold_core      = hold_q;
    assign load_done      = done_q;
    assign load_err       = err_q;

endmodule
